ram2_bus_master: RTL

//  Initiator side of the RAM2 interface: drives the external 16-bit async SRAM on behalf of the CPU.

---
 rtl/ram2_bus_master_pkg.sv | 72 +++++++
 rtl/ram2_bus_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram2_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// ram2_bus_master_pkg
// Shared definitions for the RAM2 bus master:
//   - default bus widths and the default strobe-stretch count
//   - FSM state encoding
//   - active-low SRAM strobe levels
//   - a helper that maps an FSM state to the SRAM strobe/driver pattern
// ---------------------------------------------------------------------------
package ram2_bus_master_pkg;

  // Default widths (data/instruction bus, CPU word address, SRAM pins).
  localparam int unsigned DATA_BUS_W      = 16;
  localparam int unsigned DATA_ADDR_BUS_W = 16;
  localparam int unsigned SRAM_ADDR_BUS_W = 18;
  localparam int unsigned WAIT_CYCLES_DEF = 1;

  // SRAM strobe levels (all strobes are active low).
  localparam logic RAM_CHIP_ENABLE   = 1'b0;
  localparam logic RAM_CHIP_DISABLE  = 1'b1;
  localparam logic RAM_READ_ENABLE   = 1'b0;
  localparam logic RAM_READ_DISABLE  = 1'b1;
  localparam logic RAM_WRITE_ENABLE  = 1'b0;
  localparam logic RAM_WRITE_DISABLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } ram2_state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } sram_ctrl_t;

  localparam sram_ctrl_t SRAM_CTRL_IDLE = '{
    ce_n:  RAM_CHIP_DISABLE,
    oe_n:  RAM_READ_DISABLE,
    we_n:  RAM_WRITE_DISABLE,
    dq_oe: 1'b0
  };

  // Strobe pattern for a given state. we_n is only ever enabled in a state
  // that also drives the data pins, so the SRAM never latches floating data.
  function automatic sram_ctrl_t sram_ctrl_for(input ram2_state_e st);
    sram_ctrl_t c;
    c = SRAM_CTRL_IDLE;
    case (st)
      ST_RD: begin
        c.ce_n = RAM_CHIP_ENABLE;
        c.oe_n = RAM_READ_ENABLE;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        c.ce_n  = RAM_CHIP_ENABLE;
        c.dq_oe = 1'b1;
      end
      ST_WR_PULSE: begin
        c.ce_n  = RAM_CHIP_ENABLE;
        c.we_n  = RAM_WRITE_ENABLE;
        c.dq_oe = 1'b1;
      end
      default: c = SRAM_CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram2_bus_master.sv
// ---------------------------------------------------------------------------
// ram2_bus_master
// Initiator side of the RAM2 interface. Drives an external 16-bit async SRAM
// for the CPU, arbitrating instruction fetch (IF) against load/store (MEM);
// MEM always wins. Produces stretched read/write strobes, returns data with
// one-cycle done pulses and requests a pipeline stall while work is pending.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   if_req/if_addr            fetch request (level) and pc
//   if_inst/if_valid          fetched instruction and one-cycle done pulse
//   mem_req/mem_we            load/store request (level), 1 = store
//   mem_addr/mem_wdata        load/store address and store data
//   mem_rdata/mem_done        load data and one-cycle done pulse
//   stall_o                   pipeline stall request (combinational)
//   sram_addr                 SRAM address (CPU address zero-extended)
//   sram_dq_o/sram_dq_oe      SRAM write data and pin-drive enable
//   sram_dq_i                 SRAM read data
//   sram_ce_n/oe_n/we_n       active-low SRAM strobes
//
// All SRAM-side outputs are registered from the next state, so the strobe
// pattern always lines up with the current FSM state and is glitch-free.
// ---------------------------------------------------------------------------
module ram2_bus_master
  import ram2_bus_master_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_BUS_W,
  parameter int unsigned ADDR_W      = DATA_ADDR_BUS_W,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_BUS_W,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic [DATA_W-1:0]      if_inst,
  output logic                   if_valid,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_done,
  output logic                   stall_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [DATA_W-1:0]      sram_dq_i,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  // Strobe-stretch reload value; the counter counts down to zero.
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  ram2_state_e            state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   is_mem_q, is_mem_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  sram_ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0]      if_inst_q, if_inst_d;
  logic [DATA_W-1:0]      mem_rdata_q, mem_rdata_d;
  logic                   if_valid_q, if_valid_d;
  logic                   mem_done_q, mem_done_d;
  logic                   done_s;
  logic                   rd_capture_s;

  // Next-state logic: arbitration in IDLE, strobe stretching, done detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_mem_d = is_mem_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // MEM is looked at first; request, address and data are captured
        // here and the inputs are ignored until the access finishes.
        if (mem_req) begin
          is_mem_d = 1'b1;
          addr_d   = SRAM_ADDR_W'(mem_addr);
          if (mem_we) begin
            wdata_d = mem_wdata;
            state_d = ST_WR_SETUP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_RD;
          end
        end else if (if_req) begin
          is_mem_d = 1'b0;
          addr_d   = SRAM_ADDR_W'(if_addr);
          cnt_d    = WAIT_LOAD;
          state_d  = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_q == 3'd0) begin
          done_s  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WR_SETUP: begin
        cnt_d   = WAIT_LOAD;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        // The store is committed by the rising we_n edge at the start of
        // WR_HOLD, so the done pulse is raised together with that cycle;
        // this keeps the store latency at WAIT_CYCLES+3.
        if (cnt_q == 3'd0) begin
          done_s  = 1'b1;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WR_HOLD: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-data capture and done-pulse routing to the latched requester.
  always_comb begin
    rd_capture_s = (state_q == ST_RD) && (cnt_q == 3'd0);
    if_inst_d    = if_inst_q;
    mem_rdata_d  = mem_rdata_q;
    if (rd_capture_s && is_mem_q) begin
      mem_rdata_d = sram_dq_i;
    end else if (rd_capture_s) begin
      if_inst_d = sram_dq_i;
    end else begin
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
    end
    mem_done_d = done_s & is_mem_q;
    if_valid_d = done_s & ~is_mem_q;
    ctrl_d     = sram_ctrl_for(state_d);
  end

  // FSM, access context and all registered outputs; reset aborts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      is_mem_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= SRAM_CTRL_IDLE;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_mem_q    <= is_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_inst    = if_inst_q;
  assign if_valid   = if_valid_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_done   = mem_done_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = ctrl_q.dq_oe;
  assign sram_ce_n  = ctrl_q.ce_n;
  assign sram_oe_n  = ctrl_q.oe_n;
  assign sram_we_n  = ctrl_q.we_n;

  // Stall drops in the same cycle as the matching done pulse.
  assign stall_o = (mem_req & ~mem_done_q) | (if_req & ~if_valid_q);

endmodule
